// File: rtl/core_mul_iter.sv
// ---------------------------------------------------------------------------
// core_mul_iter
//   Iterative multiply / multiply-accumulate unit for the execute stage.
//   Executes MUL, MLA, UMULL, SMULL, UMLAL and SMLAL with a shift-add
//   datapath that retires BPC multiplier bits per RUN cycle.
//
//   Signed long operations multiply magnitudes and negate the 2W-bit
//   product afterwards (FIX). The accumulate operand is then added (ACC),
//   and the result and flags are registered while leaving DONE. The
//   one-cycle valid strobe therefore appears on the cycle after DONE,
//   W/BPC+3 cycles after the start-accept edge.
//
//   Handshake: when ready=1 and start=1 and flush=0 on a rising clock edge,
//   the operands are captured and ready drops until the operation leaves
//   DONE. valid pulses for one cycle with q_lo/q_hi/n/z already updated.
//   These outputs then hold until the next result or until reset.
//   start is ignored while ready=0. flush kills an operation in RUN, FIX
//   or ACC. A result that has reached DONE is already committed, so flush
//   does not stop it.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start, flush      launch / abort
//   a, b              Rm, Rs operands
//   c_lo, c_hi        accumulate words (c_hi used by long ops only)
//   add               accumulate enable
//   long_mul          2W-bit result when 1
//   signed_mul        signed operands (long ops only)
//   ready             idle, can accept start
//   valid             one-cycle result strobe
//   q_lo, q_hi        result words (q_hi = 0 for short ops)
//   n, z              negative / zero flags of the result
// ---------------------------------------------------------------------------
module core_mul_iter #(
  parameter int W   = 32,
  parameter int BPC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         flush,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c_lo,
  input  logic [W-1:0] c_hi,
  input  logic         add,
  input  logic         long_mul,
  input  logic         signed_mul,
  output logic         ready,
  output logic         valid,
  output logic [W-1:0] q_lo,
  output logic [W-1:0] q_hi,
  output logic         n,
  output logic         z
);

  localparam int STEPS = W / BPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STEPS - 1);
  localparam logic [W-1:0]   ONE_W    = W'(1);
  localparam logic [2*W-1:0] ONE_2W   = (2*W)'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_FIX  = 3'd2,
    S_ACC  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Datapath registers
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;   // multiplicand, pre-shifted to the current digit
  logic [W-1:0]   mplier;  // remaining multiplier bits, consumed LSB first
  logic [CW-1:0]  cnt;
  logic [W-1:0]   c_lo_r;
  logic [W-1:0]   c_hi_r;
  logic           add_r;
  logic           long_r;
  logic           neg_r;

  // Output registers
  logic           valid_r;
  logic [W-1:0]   q_lo_r;
  logic [W-1:0]   q_hi_r;
  logic           n_r;
  logic           z_r;

  // Combinational helpers
  logic           accept;
  logic           sgn;
  logic [W-1:0]   a_abs;
  logic [W-1:0]   b_abs;
  logic [2*W-1:0] pp;
  logic [2*W-1:0] acc_add;

  // -------------------------------------------------------------------------
  // Operand conditioning
  // -------------------------------------------------------------------------
  // Short ops are sign-agnostic in the low word, so signedness only matters
  // for long ops. The magnitude of the most negative value wraps to itself,
  // which is the correct unsigned magnitude.
  assign sgn    = signed_mul & long_mul;
  assign accept = (state == S_IDLE) && start && !flush;

  always_comb begin
    a_abs = a;
    b_abs = b;
    if (sgn && a[W-1]) a_abs = ~a + ONE_W;
    if (sgn && b[W-1]) b_abs = ~b + ONE_W;
  end

  // Partial product of the multiplicand and the low BPC multiplier bits.
  // mcand is already shifted by cnt*BPC, so pp lands at the right weight.
  always_comb begin
    pp = '0;
    for (int i = 0; i < BPC; i++) begin
      if (mplier[i]) pp = pp + (mcand << i);
    end
  end

  // Accumulate operand: a full 2W-bit pair for long ops, zero-extended Rn
  // for MLA.
  always_comb begin
    acc_add = {{W{1'b0}}, c_lo_r};
    if (long_r) acc_add = {c_hi_r, c_lo_r};
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state and ready
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (accept) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (flush)                 state_nxt = S_IDLE;
        else if (cnt == CNT_LAST)  state_nxt = S_FIX;
      end
      S_FIX: begin
        if (flush) state_nxt = S_IDLE;
        else       state_nxt = S_ACC;
      end
      S_ACC: begin
        if (flush) state_nxt = S_IDLE;
        else       state_nxt = S_DONE;
      end
      S_DONE: begin
        // The result is committed here; flush has nothing left to kill.
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  // Updates made during a flushed cycle are harmless. The next accept
  // reloads every working register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      c_lo_r <= '0;
      c_hi_r <= '0;
      add_r  <= 1'b0;
      long_r <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc    <= '0;
            mcand  <= {{W{1'b0}}, a_abs};
            mplier <= b_abs;
            cnt    <= '0;
            c_lo_r <= c_lo;
            c_hi_r <= c_hi;
            add_r  <= add;
            long_r <= long_mul;
            neg_r  <= sgn & (a[W-1] ^ b[W-1]);
          end
        end
        S_RUN: begin
          acc    <= acc + pp;
          mcand  <= mcand << BPC;
          mplier <= mplier >> BPC;
          cnt    <= cnt + CNT_ONE;
        end
        S_FIX: begin
          if (neg_r) acc <= ~acc + ONE_2W;
        end
        S_ACC: begin
          // Overflow past 2W bits is discarded.
          if (add_r) acc <= acc + acc_add;
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Result registers: loaded when leaving DONE, held otherwise
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      q_lo_r  <= '0;
      q_hi_r  <= '0;
      n_r     <= 1'b0;
      z_r     <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (state == S_DONE) begin
        valid_r <= 1'b1;
        q_lo_r  <= acc[W-1:0];
        if (long_r) begin
          q_hi_r <= acc[2*W-1:W];
          n_r    <= acc[2*W-1];
          z_r    <= (acc == '0);
        end else begin
          q_hi_r <= '0;
          n_r    <= acc[W-1];
          z_r    <= (acc[W-1:0] == '0);
        end
      end
    end
  end

  assign valid = valid_r;
  assign q_lo  = q_lo_r;
  assign q_hi  = q_hi_r;
  assign n     = n_r;
  assign z     = z_r;

endmodule
